// File: rtl/spectrum_frame_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// dav_pkg
// Shared types and constants for the spectrum frame controller.
//   state_t      : controller FSM states
//   FRAME_CNT_W  : width of the completed-update counter
//   SKIP_CNT_W   : width of the ignored-vsync counter
// No ports (package).
// -----------------------------------------------------------------------------
package dav_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    CALC,
    PUBLISH
  } state_t;

  localparam int FRAME_CNT_W = 16;
  localparam int SKIP_CNT_W  = 8;

endpackage

// File: rtl/spectrum_frame_ctrl_if.sv
// -----------------------------------------------------------------------------
// spectrum_frame_ctrl_if
// Bundles the FFT handshake and the bar-height bus of the spectrum controller.
//   fft_start  : one-cycle start pulse towards the FFT engine
//   fft_done   : FFT completion, fft_out valid while high
//   fft_out    : packed complex bins, bin k = {re, im} at [k*2*HALF_W +: 2*HALF_W]
//   bars       : packed bar heights, bin k at [k*BAR_W +: BAR_W]
//   bars_valid : one-cycle pulse once every bar has been rewritten
// Modports: master = controller side, slave = FFT engine / renderer side.
// -----------------------------------------------------------------------------
interface spectrum_frame_ctrl_if #(
  parameter int NUM_BINS = 16,
  parameter int HALF_W   = 18,
  parameter int BAR_W    = 18
);

  logic                            fft_start;
  logic                            fft_done;
  logic [NUM_BINS*2*HALF_W-1:0]    fft_out;
  logic [NUM_BINS*BAR_W-1:0]       bars;
  logic                            bars_valid;

  modport master (
    output fft_start,
    output bars,
    output bars_valid,
    input  fft_done,
    input  fft_out
  );

  modport slave (
    input  fft_start,
    input  bars,
    input  bars_valid,
    output fft_done,
    output fft_out
  );

endinterface

// File: rtl/spectrum_frame_ctrl_bin_magnitude.sv
// -----------------------------------------------------------------------------
// bin_magnitude
// Combinational |re| + |im| magnitude, right shifted by MAG_SHIFT and saturated
// to BAR_W bits. Shared by all bins of the controller, one bin per cycle.
//   re, im : signed HALF_W-bit bin components
//   mag    : unsigned BAR_W-bit saturated magnitude
// -----------------------------------------------------------------------------
module bin_magnitude #(
  parameter int HALF_W    = 18,
  parameter int BAR_W     = 18,
  parameter int MAG_SHIFT = 0
) (
  input  logic signed [HALF_W-1:0] re,
  input  logic signed [HALF_W-1:0] im,
  output logic        [BAR_W-1:0]  mag
);

  localparam int SUM_W = HALF_W + 1;

  logic [HALF_W-1:0] abs_re;
  logic [HALF_W-1:0] abs_im;
  logic [SUM_W-1:0]  sum;
  logic [SUM_W-1:0]  shifted;

  // Absolute values are kept unsigned in HALF_W bits, which holds the
  // magnitude of the most negative input exactly. The sum gets one extra bit
  // so it never wraps.
  always_comb begin
    abs_re  = re[HALF_W-1] ? (~$unsigned(re) + 1'b1) : $unsigned(re);
    abs_im  = im[HALF_W-1] ? (~$unsigned(im) + 1'b1) : $unsigned(im);
    sum     = {1'b0, abs_re} + {1'b0, abs_im};
    shifted = sum >> MAG_SHIFT;
  end

  // A bar at least as wide as the sum needs no clamp; otherwise any set bit
  // above the bar width clamps to full scale.
  if (BAR_W >= SUM_W) begin : g_wide
    assign mag = BAR_W'(shifted);
  end else begin : g_narrow
    assign mag = (|shifted[SUM_W-1:BAR_W]) ? {BAR_W{1'b1}} : shifted[BAR_W-1:0];
  end

endmodule

// File: rtl/spectrum_frame_ctrl.sv
// -----------------------------------------------------------------------------
// spectrum_frame_ctrl
// Frame-synchronised spectrum capture controller (clk_25 domain). Each vsync
// rise while idle starts one FFT run; the returned bins are snapshotted and
// converted, one bin per cycle, into bar heights for the VGA renderer.
// Optional build macro: SPECTRUM_PEAK_HOLD_EN (peak-hold with decay on bars).
// Ports:
//   clk, rst    : clock and synchronous active-high reset
//   vsync       : vertical sync level, already synchronous to clk
//   bus         : FFT handshake + bar bus (spectrum_frame_ctrl_if.master)
//   busy        : high whenever the FSM is not idle
//   frame_count : completed bar updates, wraps
//   skip_count  : vsync rises ignored while busy, saturates
//   timeout_err : sticky FFT timeout flag, cleared only by rst
// -----------------------------------------------------------------------------
module spectrum_frame_ctrl
  import dav_pkg::*;
#(
  parameter int NUM_BINS    = 16,
  parameter int HALF_W      = 18,
  parameter int BAR_W       = 18,
  parameter int MAG_SHIFT   = 0,
  parameter int DECAY_SHIFT = 3,
  parameter int TIMEOUT     = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   vsync,
  spectrum_frame_ctrl_if.master  bus,
  output logic                   busy,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic [SKIP_CNT_W-1:0]  skip_count,
  output logic                   timeout_err
);

  localparam int IDX_W  = $clog2(NUM_BINS);
  localparam int TO_W   = $clog2(TIMEOUT);
  localparam int BIN_W  = 2 * HALF_W;
  localparam int FFT_W  = NUM_BINS * BIN_W;
  localparam int BARS_W = NUM_BINS * BAR_W;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_BINS - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

  // Reject configurations the bin indexing and decay logic cannot handle.
  if (NUM_BINS < 4 || NUM_BINS > 64 || (NUM_BINS & (NUM_BINS - 1)) != 0 ||
      DECAY_SHIFT < 0 || TIMEOUT < 2) begin : g_bad_param
    $error("spectrum_frame_ctrl: illegal parameter set");
  end

  state_t                   state;
  logic                     vsync_q;
  logic                     rise;
  logic [IDX_W-1:0]         idx;
  logic [TO_W-1:0]          to_cnt;
  logic [TO_W-1:0]          to_cnt_next;
  logic [FFT_W-1:0]         snap;
  logic [BARS_W-1:0]        bars_r;
  logic                     fft_start_r;
  logic                     bars_valid_r;
  logic signed [HALF_W-1:0] cur_re;
  logic signed [HALF_W-1:0] cur_im;
  logic [BAR_W-1:0]         mag;
  logic [BAR_W-1:0]         new_bar;

  assign rise        = vsync & ~vsync_q;
  assign to_cnt_next = to_cnt + 1'b1;

  assign bus.fft_start  = fft_start_r;
  assign bus.bars       = bars_r;
  assign bus.bars_valid = bars_valid_r;

  // The bin currently being converted is picked out of the snapshot so the
  // FFT engine is free to change fft_out once fft_done drops.
  always_comb begin
    cur_re = snap[idx*BIN_W + HALF_W +: HALF_W];
    cur_im = snap[idx*BIN_W +: HALF_W];
  end

  bin_magnitude #(
    .HALF_W    (HALF_W),
    .BAR_W     (BAR_W),
    .MAG_SHIFT (MAG_SHIFT)
  ) u_mag (
    .re  (cur_re),
    .im  (cur_im),
    .mag (mag)
  );

`ifdef SPECTRUM_PEAK_HOLD_EN
  logic [BAR_W-1:0] old_bar;
  logic [BAR_W-1:0] decay_amt;
  logic [BAR_W-1:0] decayed;

  // Peak hold: a louder bin replaces the bar at once, a quieter one lets the
  // bar fall by a fraction per frame. Small bars whose fraction rounds to zero
  // still lose one step so they always settle on the current magnitude.
  always_comb begin
    old_bar   = bars_r[idx*BAR_W +: BAR_W];
    decay_amt = old_bar >> DECAY_SHIFT;
    decayed   = (decay_amt == '0) ? (old_bar - 1'b1) : (old_bar - decay_amt);
    if (mag >= old_bar) begin
      new_bar = mag;
    end else if (mag >= decayed) begin
      new_bar = mag;
    end else begin
      new_bar = decayed;
    end
  end
`else
  assign new_bar = mag;
`endif

  // The snapshot only captures on the accepted fft_done, so it needs no reset.
  always_ff @(posedge clk) begin
    if (state == WAIT && bus.fft_done) begin
      snap <= bus.fft_out;
    end
  end

  // Frame sequencer. All outputs are registered and set on the transition into
  // the state they belong to. A rise seen outside IDLE, including in the
  // PUBLISH cycle itself, is counted as a skip and never starts a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      vsync_q      <= 1'b0;
      bars_r       <= '0;
      frame_count  <= '0;
      skip_count   <= '0;
      timeout_err  <= 1'b0;
      fft_start_r  <= 1'b0;
      bars_valid_r <= 1'b0;
      busy         <= 1'b0;
      idx          <= '0;
      to_cnt       <= '0;
    end else begin
      vsync_q      <= vsync;
      fft_start_r  <= 1'b0;
      bars_valid_r <= 1'b0;

      if (rise && state != IDLE && skip_count != '1) begin
        skip_count <= skip_count + 1'b1;
      end

      case (state)
        IDLE: begin
          if (rise) begin
            state       <= START;
            fft_start_r <= 1'b1;
            busy        <= 1'b1;
          end
        end
        START: begin
          to_cnt <= '0;
          state  <= WAIT;
        end
        WAIT: begin
          to_cnt <= to_cnt_next;
          if (bus.fft_done) begin
            idx   <= '0;
            state <= CALC;
          end else if (to_cnt_next == TO_LAST) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
            busy        <= 1'b0;
          end
        end
        CALC: begin
          bars_r[idx*BAR_W +: BAR_W] <= new_bar;
          idx <= idx + 1'b1;
          if (idx == IDX_LAST) begin
            state        <= PUBLISH;
            bars_valid_r <= 1'b1;
            frame_count  <= frame_count + 1'b1;
          end
        end
        PUBLISH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
